// File: rtl/mem_if_pkg.sv
// Shared definitions for the unified-memory arbiter: bus defaults, FSM states, owner codes.
package mem_if_pkg;

  localparam int unsigned DEF_ADDR_W  = 16;
  localparam int unsigned DEF_DATA_W  = 16;
  localparam int unsigned DEF_MEM_LAT = 4;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_WAIT = 2'd1,
    ARB_RESP = 2'd2
  } arbState_t;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin pick between fetch (I) and data (D) requests.
module arb_rr2
  import mem_if_pkg::*;
(
  input  logic req_i,
  input  logic req_d,
  input  logic last_owner,
  output logic grant_valid,
  output logic grant_owner
);

  // Lone requester wins; on contention the side that did not go last wins.
  always_comb begin
    grant_valid = req_i | req_d;
    grant_owner = OWN_I;
    if (req_i && req_d) begin
      grant_owner = (last_owner == OWN_I) ? OWN_D : OWN_I;
    end else if (req_d) begin
      grant_owner = OWN_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares a single-ported fixed-latency memory between fetch and data sides,
// one access in flight, round-robin on contention.
module mem_arbiter
  import mem_if_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned MEM_LAT = DEF_MEM_LAT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  localparam int unsigned CNT_W = $clog2(MEM_LAT + 1);

  arbState_t          state, stateNext;
  logic [CNT_W-1:0]   cnt, cntNext;
  logic               lastOwner, lastOwnerNext;
  logic               grantValid, grantOwner;

  logic               memEnNext, memWrNext, iAckNext, dAckNext, busyNext, ownerNext;
  logic [ADDR_W-1:0]  memAddrNext;
  logic [DATA_W-1:0]  memWdataNext, iRdataNext, dRdataNext;

  arb_rr2 uPick (
    .req_i       (i_req),
    .req_d       (d_req),
    .last_owner  (lastOwner),
    .grant_valid (grantValid),
    .grant_owner (grantOwner)
  );

  // State register plus all registered outputs; reset abandons any in-flight access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ARB_IDLE;
      cnt       <= '0;
      lastOwner <= OWN_D;
      owner     <= OWN_I;
      mem_en    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_ack     <= 1'b0;
      d_ack     <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= stateNext;
      cnt       <= cntNext;
      lastOwner <= lastOwnerNext;
      owner     <= ownerNext;
      mem_en    <= memEnNext;
      mem_wr    <= memWrNext;
      mem_addr  <= memAddrNext;
      mem_wdata <= memWdataNext;
      i_ack     <= iAckNext;
      d_ack     <= dAckNext;
      i_rdata   <= iRdataNext;
      d_rdata   <= dRdataNext;
      busy      <= busyNext;
    end
  end

  // Next-state and next-output logic: IDLE grants, WAIT counts latency, RESP acks.
  always_comb begin
    stateNext     = state;
    cntNext       = cnt;
    lastOwnerNext = lastOwner;
    ownerNext     = owner;
    memEnNext     = 1'b0;
    memWrNext     = mem_wr;
    memAddrNext   = mem_addr;
    memWdataNext  = mem_wdata;
    iAckNext      = 1'b0;
    dAckNext      = 1'b0;
    iRdataNext    = i_rdata;
    dRdataNext    = d_rdata;

    case (state)
      ARB_IDLE: begin
        if (grantValid) begin
          ownerNext     = grantOwner;
          lastOwnerNext = grantOwner;
          cntNext       = CNT_W'(1);
          memEnNext     = 1'b1;
          if (grantOwner == OWN_D) begin
            memWrNext    = d_we;
            memAddrNext  = d_addr;
            memWdataNext = d_wdata;
          end else begin
            memWrNext    = 1'b0;
            memAddrNext  = i_addr;
          end
          stateNext = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        if (cnt == CNT_W'(MEM_LAT)) begin
          // Read data is valid only in this cycle; a write leaves d_rdata alone.
          if (owner == OWN_I) begin
            iRdataNext = mem_rdata;
            iAckNext   = 1'b1;
          end else begin
            if (!mem_wr) dRdataNext = mem_rdata;
            dAckNext = 1'b1;
          end
          memWrNext = 1'b0;
          stateNext = ARB_RESP;
        end else begin
          cntNext = cnt + CNT_W'(1);
        end
      end
      ARB_RESP: begin
        stateNext = ARB_IDLE;
      end
      default: begin
        stateNext = ARB_IDLE;
      end
    endcase

    busyNext = (stateNext != ARB_IDLE);
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (MEM_LAT=4 main instance, MEM_LAT=1 second instance).
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;

  // Main instance (MEM_LAT = 4)
  logic        i_req, d_req, d_we;
  logic [15:0] i_addr, d_addr, d_wdata;
  logic        i_ack, d_ack, mem_en, mem_wr, busy, owner;
  logic [15:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [15:0] memVal;
  logic [7:0]  age0, pos0;

  // Second instance (MEM_LAT = 1)
  logic        i_req1, d_req1, d_we1;
  logic [15:0] i_addr1, d_addr1, d_wdata1;
  logic        i_ack1, d_ack1, mem_en1, mem_wr1, busy1, owner1;
  logic [15:0] i_rdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
  logic [15:0] memVal1;

  int nChecks = 0;
  int nErrors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req1), .i_addr(i_addr1), .i_ack(i_ack1), .i_rdata(i_rdata1),
    .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1),
    .d_ack(d_ack1), .d_rdata(d_rdata1),
    .mem_en(mem_en1), .mem_wr(mem_wr1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1), .busy(busy1), .owner(owner1)
  );

  // Memory model: data valid only in the MEM_LAT-th cycle counted from the mem_en cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) age0 <= 8'd0;
    else if (mem_en) age0 <= 8'd2;
    else if (age0 != 8'd0 && age0 < 8'd20) age0 <= age0 + 8'd1;
  end
  assign pos0       = mem_en ? 8'd1 : age0;
  assign mem_rdata  = (pos0 == 8'd4) ? memVal : 16'hDEAD;
  assign mem_rdata1 = mem_en1 ? memVal1 : 16'hDEAD;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    i_req = 0; d_req = 0; d_we = 0; i_addr = 0; d_addr = 0; d_wdata = 0; memVal = 0;
    i_req1 = 0; d_req1 = 0; d_we1 = 0; i_addr1 = 0; d_addr1 = 0; d_wdata1 = 0; memVal1 = 0;
    repeat (2) nextCycle();

    // Reset state
    checkEq("rst_busy", busy, 0);
    checkEq("rst_owner", owner, 0);
    checkEq("rst_mem_en", mem_en, 0);
    checkEq("rst_mem_addr", mem_addr, 0);
    checkEq("rst_acks", {i_ack, d_ack}, 0);
    checkEq("rst_rdata", {i_rdata, d_rdata}, 0);
    rst_n = 1'b1;
    nextCycle();

    // 1. Lone I read
    i_req = 1; i_addr = 16'h0010; memVal = 16'hA5A5;
    for (int k = 1; k <= 6; k++) begin
      nextCycle();
      checkEq($sformatf("t1_mem_en_c%0d", k), mem_en, (k == 1));
      checkEq($sformatf("t1_i_ack_c%0d", k), i_ack, (k == 5));
      checkEq($sformatf("t1_d_ack_c%0d", k), d_ack, 0);
      checkEq($sformatf("t1_busy_c%0d", k), busy, (k <= 5));
      if (k == 1) checkEq("t1_mem_addr", mem_addr, 16'h0010);
      if (k == 5) begin
        checkEq("t1_i_rdata", i_rdata, 16'hA5A5);
        checkEq("t1_owner", owner, 0);
        i_req = 0;
      end
    end

    // 2. D write
    d_req = 1; d_we = 1; d_addr = 16'h0200; d_wdata = 16'h1234; memVal = 16'h7777;
    for (int k = 1; k <= 6; k++) begin
      nextCycle();
      checkEq($sformatf("t2_mem_en_c%0d", k), mem_en, (k == 1));
      checkEq($sformatf("t2_d_ack_c%0d", k), d_ack, (k == 5));
      checkEq($sformatf("t2_i_ack_c%0d", k), i_ack, 0);
      if (k <= 4) begin
        checkEq($sformatf("t2_mem_wr_c%0d", k), mem_wr, 1);
        checkEq($sformatf("t2_mem_wdata_c%0d", k), mem_wdata, 16'h1234);
        checkEq($sformatf("t2_mem_addr_c%0d", k), mem_addr, 16'h0200);
      end
      if (k == 5) begin
        checkEq("t2_d_rdata", d_rdata, 16'h0000);
        checkEq("t2_i_rdata_hold", i_rdata, 16'hA5A5);
        checkEq("t2_owner", owner, 1);
        d_req = 0; d_we = 0;
      end
    end

    // 3. Both requesting from reset release: I first, then strict alternation
    rst_n = 0;
    nextCycle();
    rst_n = 1; i_req = 1; i_addr = 16'h0100; d_req = 1; d_we = 0; d_addr = 16'h0300;
    memVal = 16'h1111;
    for (int k = 1; k <= 17; k++) begin
      nextCycle();
      checkEq($sformatf("t3_i_ack_c%0d", k), i_ack, (k == 5 || k == 17));
      checkEq($sformatf("t3_d_ack_c%0d", k), d_ack, (k == 11));
      checkEq($sformatf("t3_mem_en_c%0d", k), mem_en, (k == 1 || k == 7 || k == 13));
      if (k == 5) begin
        checkEq("t3_i_rdata", i_rdata, 16'h1111);
        memVal = 16'h2222;
      end
      if (k == 7) checkEq("t3_mem_addr_d", mem_addr, 16'h0300);
      if (k == 11) begin
        checkEq("t3_d_rdata", d_rdata, 16'h2222);
        checkEq("t3_i_rdata_hold", i_rdata, 16'h1111);
        memVal = 16'h3333;
      end
      if (k == 13) checkEq("t3_mem_addr_i", mem_addr, 16'h0100);
      if (k == 17) begin
        checkEq("t3_i_rdata2", i_rdata, 16'h3333);
        i_req = 0; d_req = 0;
      end
    end
    nextCycle();
    nextCycle();
    checkEq("t3_idle_busy", busy, 0);

    // 4. d_req raised during an I access is served next
    i_req = 1; i_addr = 16'h0030; memVal = 16'h9999;
    for (int k = 1; k <= 11; k++) begin
      nextCycle();
      if (k == 2) begin d_req = 1; d_we = 0; d_addr = 16'h0400; end
      checkEq($sformatf("t4_i_ack_c%0d", k), i_ack, (k == 5));
      checkEq($sformatf("t4_d_ack_c%0d", k), d_ack, (k == 11));
      checkEq($sformatf("t4_mem_en_c%0d", k), mem_en, (k == 1 || k == 7));
      if (k <= 6) checkEq($sformatf("t4_mem_addr_c%0d", k), mem_addr, 16'h0030);
      if (k == 7) checkEq("t4_mem_addr_d", mem_addr, 16'h0400);
      if (k == 5) begin
        checkEq("t4_i_rdata", i_rdata, 16'h9999);
        i_req = 0; memVal = 16'h4444;
      end
      if (k == 11) begin
        checkEq("t4_d_rdata", d_rdata, 16'h4444);
        d_req = 0;
      end
    end
    nextCycle();

    // 5. Reset in the middle of a D read
    d_req = 1; d_we = 0; d_addr = 16'h0500; memVal = 16'h6666;
    for (int k = 1; k <= 3; k++) nextCycle();
    checkEq("t5_busy_pre", busy, 1);
    rst_n = 0; d_req = 0;
    #1;
    checkEq("t5_busy_rst", busy, 0);
    checkEq("t5_mem_addr_rst", mem_addr, 0);
    checkEq("t5_owner_rst", owner, 0);
    checkEq("t5_d_rdata_rst", d_rdata, 0);
    checkEq("t5_mem_en_wr_rst", {mem_en, mem_wr}, 0);
    nextCycle();
    rst_n = 1;
    for (int k = 1; k <= 8; k++) begin
      nextCycle();
      checkEq($sformatf("t5_no_ack_c%0d", k), {i_ack, d_ack}, 0);
    end
    i_req = 1; i_addr = 16'h0050; memVal = 16'h5555;
    for (int k = 1; k <= 5; k++) begin
      nextCycle();
      checkEq($sformatf("t5_i_ack_c%0d", k), i_ack, (k == 5));
    end
    checkEq("t5_i_rdata", i_rdata, 16'h5555);
    i_req = 0;
    nextCycle();

    // 6. MEM_LAT = 1 instance
    i_req1 = 1; i_addr1 = 16'h0004; memVal1 = 16'hBEEF;
    for (int k = 1; k <= 3; k++) begin
      nextCycle();
      checkEq($sformatf("t6_mem_en_c%0d", k), mem_en1, (k == 1));
      checkEq($sformatf("t6_i_ack_c%0d", k), i_ack1, (k == 2));
      if (k == 1) checkEq("t6_mem_addr", mem_addr1, 16'h0004);
      if (k == 2) begin
        checkEq("t6_i_rdata", i_rdata1, 16'hBEEF);
        i_req1 = 0;
      end
    end

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
